// File: rtl/pfb_deadlock_watchdog.sv
// Purpose: qualify a sustained all-process stall against THRESH, then list each blocked monitor index.
// Latency: deadlock rises on the edge sampling the THRESH-th stalled cycle; the scan takes 1 cycle per clear bit.
// Backpressure: a report holds report_valid/report_idx until report_ready; the scan pauses meanwhile.
// Build option: define PFB_DEADLOCK_SNAPSHOT_EN to expose the captured block vector on `snapshot`.
module pfb_deadlock_watchdog #(
    parameter int N_MON  = 8,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_MON-1:0] mon_block,
    input  logic [N_MON-1:0] mon_idle,
    output logic             deadlock,
    output logic             report_valid,
    output logic [IDX_W-1:0] report_idx,
    input  logic             report_ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [N_MON-1:0] snapshot
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATCH  = 3'd1,
        SCAN   = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_MON - 1);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state;
    logic [N_MON-1:0] cap;
    logic [IDX_W-1:0] scan_idx;
    logic             stalled;

    // A stall needs at least one blocked process and no process making progress.
    assign stalled = (|mon_block) & (&(mon_block | mon_idle));

    // Watchdog FSM: stall qualification, capture, then ordered scan/report of blocked indices.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            deadlock     <= 1'b0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            stall_cnt    <= '0;
            cap          <= '0;
            scan_idx     <= '0;
        end else if (!enable) begin
            // Disarming abandons any scan in progress and clears every visible flag.
            state        <= IDLE;
            deadlock     <= 1'b0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            stall_cnt    <= '0;
            cap          <= '0;
            scan_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    state     <= WATCH;
                end

                WATCH: begin
                    if (stalled) begin
                        if (stall_cnt != CNT_MAX) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                        if (stall_cnt == THRESH_M1) begin
                            // Freeze the culprit set; later input changes no longer matter.
                            cap      <= mon_block;
                            deadlock <= 1'b1;
                            scan_idx <= '0;
                            state    <= SCAN;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end

                SCAN: begin
                    if (cap[scan_idx]) begin
                        report_idx   <= scan_idx;
                        report_valid <= 1'b1;
                        state        <= REPORT;
                    end else if (scan_idx == LAST_IDX) begin
                        state <= HALT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end

                REPORT: begin
                    // report_idx stays put until the consumer takes it.
                    if (report_valid && report_ready) begin
                        report_valid <= 1'b0;
                        if (scan_idx == LAST_IDX) begin
                            state <= HALT;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                            state    <= SCAN;
                        end
                    end
                end

                HALT: begin
                    report_valid <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    deadlock     <= 1'b0;
                    report_valid <= 1'b0;
                    stall_cnt    <= '0;
                end
            endcase
        end
    end

`ifdef PFB_DEADLOCK_SNAPSHOT_EN
    // The capture register is only non-zero from detection until IDLE, so it doubles as the snapshot.
    assign snapshot = cap;
`else
    assign snapshot = '0;
`endif

endmodule

// File: tb/tb_pfb_deadlock_watchdog.sv
// Directed bench for pfb_deadlock_watchdog with THRESH=4, N_MON=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Ends with one summary line.
module tb_pfb_deadlock_watchdog;

    localparam int N_MON  = 8;
    localparam int THRESH = 4;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 3;

`ifdef PFB_DEADLOCK_SNAPSHOT_EN
    localparam logic [7:0] SNAP_A4 = 8'hA4;
`else
    localparam logic [7:0] SNAP_A4 = 8'h00;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [N_MON-1:0] mon_block;
    logic [N_MON-1:0] mon_idle;
    logic             deadlock;
    logic             report_valid;
    logic [IDX_W-1:0] report_idx;
    logic             report_ready;
    logic [CNT_W-1:0] stall_cnt;
    logic [N_MON-1:0] snapshot;

    int errors = 0;
    int checks = 0;

    pfb_deadlock_watchdog #(
        .N_MON (N_MON),
        .THRESH(THRESH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mon_block   (mon_block),
        .mon_idle    (mon_idle),
        .deadlock    (deadlock),
        .report_valid(report_valid),
        .report_idx  (report_idx),
        .report_ready(report_ready),
        .stall_cnt   (stall_cnt),
        .snapshot    (snapshot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    int          cnt_viol;
    int          pulses;
    int unsigned exp_v [12];
    int unsigned exp_i [12];
    int unsigned pat_st[8];
    int unsigned pat_ct[7];

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        mon_block    = '0;
        mon_idle     = '0;
        report_ready = 1'b0;
        step(2);

        // Reset state
        check("rst_deadlock", 32'(deadlock), 32'd0);
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_idx", 32'(report_idx), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_snapshot", 32'(snapshot), 32'd0);
        reset = 1'b0;
        step(1);

        // Single blocked process, everyone else idle: detect, one report of idx 0, then HALT
        mon_block    = 8'h01;
        mon_idle     = 8'hFE;
        report_ready = 1'b1;
        enable       = 1'b1;
        step(1);
        check("t1_first_watch_cnt", 32'(stall_cnt), 32'd0);
        step(3);
        check("t1_cnt3", 32'(stall_cnt), 32'd3);
        check("t1_no_deadlock_yet", 32'(deadlock), 32'd0);
        step(1);
        check("t1_deadlock", 32'(deadlock), 32'd1);
        check("t1_scan_no_valid", 32'(report_valid), 32'd0);
        step(1);
        check("t1_report_valid", 32'(report_valid), 32'd1);
        check("t1_report_idx", 32'(report_idx), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (report_valid) pulses++;
        end
        check("t1_no_more_reports", 32'(pulses), 32'd0);
        check("t1_halt_deadlock", 32'(deadlock), 32'd1);
        enable = 1'b0;
        step(1);
        check("t1_disable_deadlock", 32'(deadlock), 32'd0);

        // Stall 3, one progress cycle, then stall 4: counter restarts
        pat_st = '{1, 1, 1, 0, 1, 1, 1, 1};
        pat_ct = '{1, 2, 3, 0, 1, 2, 3};
        mon_block = 8'h01;
        mon_idle  = 8'hFE;
        enable    = 1'b1;
        step(1);
        for (int i = 0; i < 7; i++) begin
            mon_idle = (pat_st[i] != 0) ? 8'hFE : 8'h00;
            step(1);
            check($sformatf("t2_cnt_%0d", i), 32'(stall_cnt), 32'(pat_ct[i]));
            check($sformatf("t2_nodl_%0d", i), 32'(deadlock), 32'd0);
        end
        mon_idle = (pat_st[7] != 0) ? 8'hFE : 8'h00;
        step(1);
        check("t2_deadlock_after_run2", 32'(deadlock), 32'd1);
        enable = 1'b0;
        step(1);

        // Vector A4 with ready high: reports 2,5,7 as single-cycle pulses; inputs changed after capture
        exp_v = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        exp_i = '{0, 0, 2, 0, 0, 0, 5, 0, 0, 7, 0, 0};
        mon_block    = 8'hA4;
        mon_idle     = 8'h5B;
        report_ready = 1'b1;
        enable       = 1'b1;
        step(1);
        step(4);
        check("t3_deadlock", 32'(deadlock), 32'd1);
        mon_block = 8'hFF;
        mon_idle  = 8'h00;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check($sformatf("t3_valid_%0d", i + 1), 32'(report_valid), exp_v[i]);
            if (exp_v[i] != 0) begin
                check($sformatf("t3_idx_%0d", i + 1), 32'(report_idx), exp_i[i]);
            end
        end
        check("t3_halt_deadlock", 32'(deadlock), 32'd1);
        check("t3_snapshot", 32'(snapshot), 32'(SNAP_A4));
        enable = 1'b0;
        step(1);
        check("t3_disable_snapshot", 32'(snapshot), 32'd0);

        // Same vector, ready withheld for 5 cycles while idx 5 is offered
        mon_block    = 8'hA4;
        mon_idle     = 8'h5B;
        report_ready = 1'b1;
        enable       = 1'b1;
        step(1);
        step(4);
        step(3);
        check("t4_idx2", 32'(report_idx), 32'd2);
        step(4);
        check("t4_valid5", 32'(report_valid), 32'd1);
        check("t4_idx5", 32'(report_idx), 32'd5);
        report_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("t4_hold_valid_%0d", i), 32'(report_valid), 32'd1);
            check($sformatf("t4_hold_idx_%0d", i), 32'(report_idx), 32'd5);
        end
        report_ready = 1'b1;
        step(1);
        check("t4_after_hs_valid", 32'(report_valid), 32'd0);
        step(2);
        check("t4_valid7", 32'(report_valid), 32'd1);
        check("t4_idx7", 32'(report_idx), 32'd7);
        step(1);
        check("t4_halt_valid", 32'(report_valid), 32'd0);
        check("t4_halt_deadlock", 32'(deadlock), 32'd1);
        enable = 1'b0;
        step(1);

        // Blocked process but others progressing: never a stall
        mon_block = 8'h01;
        mon_idle  = 8'h00;
        enable    = 1'b1;
        cnt_viol  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (stall_cnt != 0 || deadlock) cnt_viol++;
        end
        check("t5_no_stall_cycles", 32'(cnt_viol), 32'd0);
        enable = 1'b0;
        step(1);

        // enable dropped while a report is pending
        mon_block    = 8'hA4;
        mon_idle     = 8'h5B;
        report_ready = 1'b0;
        enable       = 1'b1;
        step(1);
        step(4);
        step(3);
        check("t6_in_report", 32'(report_valid), 32'd1);
        enable = 1'b0;
        step(1);
        check("t6_dis_deadlock", 32'(deadlock), 32'd0);
        check("t6_dis_valid", 32'(report_valid), 32'd0);
        check("t6_dis_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t6_dis_snapshot", 32'(snapshot), 32'd0);
        check("t6_dis_idx", 32'(report_idx), 32'd0);

        // reset asserted mid-scan, then no leftover report
        enable = 1'b1;
        step(1);
        step(4);
        step(1);
        check("t7_in_scan_deadlock", 32'(deadlock), 32'd1);
        reset     = 1'b1;
        mon_block = 8'h00;
        mon_idle  = 8'h00;
        step(1);
        check("t7_rst_deadlock", 32'(deadlock), 32'd0);
        check("t7_rst_valid", 32'(report_valid), 32'd0);
        check("t7_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t7_rst_snapshot", 32'(snapshot), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (report_valid || deadlock) pulses++;
        end
        check("t7_no_partial_report", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfb_deadlock_watchdog.md
# pfb_deadlock_watchdog

Simulation-side deadlock watchdog for the `pfb_multichannel` co-simulation harness. Collects the `block` outputs of the per-process deadlock monitors together with each process's idle flag, and qualifies a sustained system-wide stall against a cycle threshold. On a confirmed deadlock it scans the captured block vector and reports each blocked monitor index over a valid/ready handshake, so the testbench can log the culprits in order.

## Interface
- `N_MON`, 8: number of monitored processes (≥2)
- `THRESH`, 1024: consecutive stalled cycles required to declare deadlock (1 ≤ THRESH ≤ 2^CNT_W−1)
- `CNT_W`, 16: stall counter width
- `IDX_W`, 3: report index width, equal to ceil(log2(N_MON))

Ports:
- `clock`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  watchdog armed; low forces IDLE
- `mon_block`  in  N_MON  per-process `block` from the deadlock monitors
- `mon_idle`  in  N_MON  per-process idle flags
- `deadlock`  out  1  sticky deadlock flag
- `report_valid`  out  1  `report_idx` is valid
- `report_idx`  out  IDX_W  index of a blocked monitor
- `report_ready`  in  1  testbench consumes report
- `stall_cnt`  out  CNT_W  current consecutive-stall count
- `snapshot`  out  N_MON  block vector captured at detection; see Configuration

## Operation
- stalled = (|mon_block) & (&(mon_block | mon_idle)). At least one process is blocked and none is making progress.
- FSM states: IDLE, WATCH, SCAN, REPORT, HALT.
- **IDLE**
  - stall_cnt = 0; outputs are low.
  - Moves to WATCH when enable = 1.
- **WATCH**
  - stall_cnt increments on each stalled cycle and saturates at 2^CNT_W−1.
  - It clears to 0 on any non-stalled cycle.
  - When stalled and stall_cnt == THRESH−1:
    - capture the vector: cap ← mon_block;
    - deadlock ← 1;
    - scan index ← 0;
    - go to SCAN.
- **SCAN**
  - Examines cap[idx] once per cycle.
  - If set: go to REPORT with report_idx = idx.
  - If clear and idx == N_MON−1: go to HALT.
  - Otherwise: idx ← idx+1.
- **REPORT**
  - report_valid = 1, and report_idx is held stable until report_ready.
  - On valid & ready:
    - if idx == N_MON−1, go to HALT;
    - otherwise idx ← idx+1 and go to SCAN.
- **HALT**
  - deadlock stays 1 and report_valid = 0.
  - The FSM stays in HALT until reset or enable = 0.
- **enable = 0** in any state: go to IDLE on the next edge.
  - Clears deadlock, report_valid and stall_cnt.
  - Any scan in progress is abandoned.
- mon_block and mon_idle are ignored outside WATCH. The captured vector is not affected by later input changes.

## Timing
- Reset values:
  - FSM = IDLE;
  - deadlock = 0, report_valid = 0, report_idx = 0;
  - stall_cnt = 0, snapshot = 0.
- First WATCH cycle is the cycle after enable is sampled high in IDLE.
- Detection latency: deadlock rises on the edge that samples the THRESH-th consecutive stalled cycle. It is visible the following cycle.
- A single non-stalled cycle at any point before the THRESH-th stalled cycle restarts the count from 0.
- Scan cost:
  - 1 cycle per clear bit;
  - each set bit costs 1 SCAN cycle plus at least 1 REPORT cycle.
- Reports are issued in ascending index order, one per handshake. report_idx changes only after a handshake.
- If report_ready is held high, report_valid pulses for exactly 1 cycle per blocked index.
- Reset asserted mid-SCAN or mid-REPORT: all outputs return to reset values on the next edge, and no partial report is completed.

## Configuration
- `PFB_DEADLOCK_SNAPSHOT_EN`
  - Defined: `snapshot` holds the captured vector from the detection edge until leaving HALT, and clears on IDLE or reset.
  - Undefined: `snapshot` is tied to 0 and the capture register is used only internally. Detection and report behaviour are identical in both builds.

## Test plan
- THRESH=4, mon_block=8'h01, mon_idle=8'hFE, held constant:
  - deadlock=1 the cycle after the 4th stalled cycle;
  - one report, idx=0; then HALT.
- THRESH=4, stall for 3 cycles, 1 non-stalled cycle, then stall for 4 cycles:
  - stall_cnt shows 1,2,3,0,1,2,3;
  - deadlock asserts only after the second run.
- mon_block=8'hA4 at detection, report_ready tied high:
  - report_idx sequence 2,5,7, each with a one-cycle valid;
  - HALT 8 SCAN cycles after detection.
- Same vector, report_ready low for 5 cycles at idx 5:
  - report_valid and idx 5 held stable for all 5 cycles;
  - then idx 7.
- mon_block=8'h01 with mon_idle=8'h00 (others progressing):
  - stall_cnt stays 0 and deadlock never asserts.
- enable dropped during REPORT, and reset asserted during SCAN:
  - deadlock=0, report_valid=0, stall_cnt=0 on the next cycle;
  - snapshot=0 when the macro is defined.
